// File: rtl/mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mul_pipe
// Brief    : Parametrised pipelined integer multiplier with valid/ready on both
//            sides, per-operation signed/unsigned mode and bubble collapsing.
//            Define MUL_PIPE_SATURATE_EN to saturate the truncated product and
//            add the sat_flag output.
// Revision : 1.0 - initial release
// ============================================================================
module mul_pipe #(
    parameter int WIDTH        = 8,
    parameter int LATENCY      = 3,
    parameter int FULL_PRODUCT = 0,
    localparam int OW          = (FULL_PRODUCT != 0) ? 2*WIDTH : WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OW-1:0]    O
`ifdef MUL_PIPE_SATURATE_EN
    ,
    output logic             sat_flag
`endif
);

`ifdef MUL_PIPE_SATURATE_EN
    function automatic logic [2*WIDTH-1:0] wide_prod(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b,
                                                     input logic sgn);
        logic [2*WIDTH-1:0] ea;
        logic [2*WIDTH-1:0] eb;
        if (sgn) begin
            ea = (2*WIDTH)'($signed(a));
            eb = (2*WIDTH)'($signed(b));
        end else begin
            ea = (2*WIDTH)'(a);
            eb = (2*WIDTH)'(b);
        end
        return ea * eb;
    endfunction

    // Signed results fit only if the top WIDTH+1 bits are a pure sign extension.
    function automatic logic sat_hit(input logic [2*WIDTH-1:0] p, input logic sgn);
        if (sgn)
            return (p[2*WIDTH-1:WIDTH-1] != '0) && (p[2*WIDTH-1:WIDTH-1] != '1);
        return p[2*WIDTH-1:WIDTH] != '0;
    endfunction

    function automatic logic sat_of(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    input logic sgn);
        return (FULL_PRODUCT == 0) && sat_hit(wide_prod(a, b, sgn), sgn);
    endfunction
`endif

    // Multiplying in OW bits gives the exact product when OW=2*WIDTH and the
    // mode-independent wrapped product when OW=WIDTH.
    function automatic logic [OW-1:0] mul_res(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic sgn);
        logic [OW-1:0] ea;
        logic [OW-1:0] eb;
        logic [OW-1:0] res;
`ifdef MUL_PIPE_SATURATE_EN
        logic [2*WIDTH-1:0] p;
`endif
        if (sgn) begin
            ea = OW'($signed(a));
            eb = OW'($signed(b));
        end else begin
            ea = OW'(a);
            eb = OW'(b);
        end
        res = ea * eb;
`ifdef MUL_PIPE_SATURATE_EN
        p = wide_prod(a, b, sgn);
        if ((FULL_PRODUCT == 0) && sat_hit(p, sgn)) begin
            if (!sgn)
                res = '1;
            else if (p[2*WIDTH-1])
                res = {1'b1, {(OW-1){1'b0}}};
            else
                res = {1'b0, {(OW-1){1'b1}}};
        end
`endif
        return res;
    endfunction

    logic [LATENCY-1:0] vld;
    logic [LATENCY-1:0] adv;
    logic               blocked;

    // Stage k is blocked only if every later stage is full and the consumer stalls.
    always_comb begin
        adv     = '0;
        blocked = 1'b0;
        for (int k = 0; k < LATENCY; k++) begin
            blocked = !out_ready;
            for (int j = k + 1; j < LATENCY; j++)
                blocked = blocked && vld[j];
            adv[k] = !blocked;
        end
    end

    assign in_ready  = !vld[0] || adv[0];
    assign out_valid = vld[LATENCY-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            vld <= '0;
        end else begin
            if (in_ready)
                vld[0] <= in_valid;
            for (int k = 1; k < LATENCY; k++)
                if (!vld[k] || adv[k])
                    vld[k] <= vld[k-1];
        end
    end

    if (LATENCY == 1) begin : g_lat1
        logic [OW-1:0] prod_q;
`ifdef MUL_PIPE_SATURATE_EN
        logic          sat_q;
`endif
        always_ff @(posedge clock) begin
            if (reset) begin
                prod_q <= '0;
`ifdef MUL_PIPE_SATURATE_EN
                sat_q  <= 1'b0;
`endif
            end else if (in_valid && in_ready) begin
                prod_q <= mul_res(I0, I1, is_signed);
`ifdef MUL_PIPE_SATURATE_EN
                sat_q  <= sat_of(I0, I1, is_signed);
`endif
            end
        end
        assign O = prod_q;
`ifdef MUL_PIPE_SATURATE_EN
        assign sat_flag = sat_q;
`endif
    end else begin : g_latn
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic             s_q;
        logic [OW-1:0]    prod_q [1:LATENCY-1];
`ifdef MUL_PIPE_SATURATE_EN
        logic [LATENCY-1:1] sat_q;
`endif
        always_ff @(posedge clock) begin
            if (reset) begin
                a_q <= '0;
                b_q <= '0;
                s_q <= 1'b0;
                for (int k = 1; k < LATENCY; k++)
                    prod_q[k] <= '0;
`ifdef MUL_PIPE_SATURATE_EN
                sat_q <= '0;
`endif
            end else begin
                if (in_valid && in_ready) begin
                    a_q <= I0;
                    b_q <= I1;
                    s_q <= is_signed;
                end
                // The product is formed on the stage-0 to stage-1 transfer.
                if (vld[0] && adv[0]) begin
                    prod_q[1] <= mul_res(a_q, b_q, s_q);
`ifdef MUL_PIPE_SATURATE_EN
                    sat_q[1]  <= sat_of(a_q, b_q, s_q);
`endif
                end
                for (int k = 2; k < LATENCY; k++) begin
                    if (vld[k-1] && adv[k-1]) begin
                        prod_q[k] <= prod_q[k-1];
`ifdef MUL_PIPE_SATURATE_EN
                        sat_q[k]  <= sat_q[k-1];
`endif
                    end
                end
            end
        end
        assign O = prod_q[LATENCY-1];
`ifdef MUL_PIPE_SATURATE_EN
        assign sat_flag = sat_q[LATENCY-1];
`endif
    end

endmodule
`default_nettype wire
